// File: rtl/gate_activation_pkg.sv
// Shared definitions for the LSTM gate pipeline: Q-format sizing, FSM states,
// activation selectors and ONE/HALF helpers also used by the cell-state stage.
package gate_activation_pkg;

  localparam int DEF_NROW = 16;
  localparam int DEF_QN   = 6;
  localparam int DEF_QM   = 11;

  localparam int ACT_SIGMOID = 0;
  localparam int ACT_TANH    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_DONE = 2'd2
  } gateState_t;

  function automatic int calcBitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  function automatic int qOne(input int qm);
    return 1 << qm;
  endfunction

  function automatic int qHalf(input int qm);
    return 1 << (qm - 1);
  endfunction

endpackage

// File: rtl/gate_activation_if.sv
// Vector handshake between the dot-product unit (master) and the activation
// stage (slave), plus the activation stage's status flags.
interface gate_activation_if
  import gate_activation_pkg::*;
#(
  parameter int NROW     = DEF_NROW,
  parameter int BITWIDTH = calcBitwidth(DEF_QN, DEF_QM)
);

  logic                     dataReady;
  logic [BITWIDTH*NROW-1:0] inputVector;
  logic [BITWIDTH*NROW-1:0] biasVector;
  logic [BITWIDTH*NROW-1:0] outputVector;
  logic                     outValid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output dataReady, inputVector, biasVector,
    input  outputVector, outValid, busy, overrun
  );

  modport slave (
    input  dataReady, inputVector, biasVector,
    output outputVector, outValid, busy, overrun
  );

endinterface

// File: rtl/gate_activation_pwl_act.sv
// Combinational single-element stage: saturating bias add followed by a
// piecewise-linear hard sigmoid or hard tanh selected by ACT_TYPE.
module pwl_act
  import gate_activation_pkg::*;
#(
  parameter int  QN       = DEF_QN,
  parameter int  QM       = DEF_QM,
  parameter int  ACT_TYPE = ACT_SIGMOID,
  localparam int BITWIDTH = calcBitwidth(QN, QM)
) (
  input  logic signed [BITWIDTH-1:0] i_x,
  input  logic signed [BITWIDTH-1:0] i_b,
  output logic signed [BITWIDTH-1:0] o_y
);

  localparam int SAT_MAX = (1 << (BITWIDTH - 1)) - 1;
  localparam int SAT_MIN = -(1 << (BITWIDTH - 1));
  localparam int ONE_I   = qOne(QM);
  localparam int NEG_ONE = -ONE_I;
  localparam int HALF_I  = qHalf(QM);

  localparam logic [BITWIDTH:0] HALF_V = HALF_I[BITWIDTH:0];

  logic signed [BITWIDTH:0]   w_sum;
  logic signed [BITWIDTH-1:0] w_sat;
  logic signed [BITWIDTH:0]   w_pre;

  // One extra bit keeps the raw sum exact before clamping back to BITWIDTH.
  assign w_sum = {i_x[BITWIDTH-1], i_x} + {i_b[BITWIDTH-1], i_b};

  always_comb begin
    w_sat = w_sum[BITWIDTH-1:0];
    if (w_sum > SAT_MAX) begin
      w_sat = SAT_MAX[BITWIDTH-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_sat = SAT_MIN[BITWIDTH-1:0];
    end
  end

  if (ACT_TYPE == ACT_TANH) begin : g_tanh
    assign w_pre = {w_sat[BITWIDTH-1], w_sat};

    always_comb begin
      o_y = w_pre[BITWIDTH-1:0];
      if (w_pre > ONE_I) begin
        o_y = ONE_I[BITWIDTH-1:0];
      end else if (w_pre < NEG_ONE) begin
        o_y = NEG_ONE[BITWIDTH-1:0];
      end
    end
  end else begin : g_sigmoid
    logic signed [BITWIDTH-1:0] w_shift;

    // Slope of 1/4 via arithmetic shift, so negative inputs round toward -inf.
    assign w_shift = w_sat >>> 2;
    assign w_pre   = {w_shift[BITWIDTH-1], w_shift} + HALF_V;

    always_comb begin
      o_y = w_pre[BITWIDTH-1:0];
      if (w_pre > ONE_I) begin
        o_y = ONE_I[BITWIDTH-1:0];
      end else if (w_pre < 0) begin
        o_y = '0;
      end
    end
  end

endmodule

// File: rtl/gate_activation.sv
// Gate activation stage: captures a dot-product vector, activates it one element
// per cycle and pulses outValid. Optional per-row bias add under GATE_ACT_BIAS_EN.
module gate_activation
  import gate_activation_pkg::*;
#(
  parameter int NROW     = DEF_NROW,
  parameter int QN       = DEF_QN,
  parameter int QM       = DEF_QM,
  parameter int ACT_TYPE = ACT_SIGMOID
) (
  input logic              clk,
  input logic              reset,
  gate_activation_if.slave bus
);

  localparam int BITWIDTH = calcBitwidth(QN, QM);
  localparam int VW       = BITWIDTH * NROW;
  localparam int IDXW     = (NROW > 1) ? $clog2(NROW) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NROW - 1);

  gateState_t        r_state;
  logic [IDXW-1:0]   r_idx;
  logic [VW-1:0]     r_xVec;
  logic [VW-1:0]     r_outVec;
  logic              r_outValid;
  logic              r_busy;
  logic              r_overrun;

  logic [BITWIDTH-1:0] w_x;
  logic [BITWIDTH-1:0] w_b;
  logic [BITWIDTH-1:0] w_y;
  logic                w_capture;

  assign w_x       = r_xVec[r_idx*BITWIDTH +: BITWIDTH];
  assign w_capture = bus.dataReady && (r_state != ST_PROC);

`ifdef GATE_ACT_BIAS_EN
  logic [VW-1:0] r_bVec;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bVec <= '0;
    end else if (w_capture) begin
      r_bVec <= bus.biasVector;
    end
  end

  assign w_b = r_bVec[r_idx*BITWIDTH +: BITWIDTH];
`else
  assign w_b = '0;
`endif

  pwl_act #(
    .QN       (QN),
    .QM       (QM),
    .ACT_TYPE (ACT_TYPE)
  ) u_pwlAct (
    .i_x (w_x),
    .i_b (w_b),
    .o_y (w_y)
  );

  // A dataReady in PROC is dropped (never re-captured) and only flags overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_xVec     <= '0;
      r_outVec   <= '0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (w_capture) begin
        r_xVec <= bus.inputVector;
        r_idx  <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.dataReady) begin
            r_state <= ST_PROC;
            r_busy  <= 1'b1;
          end
        end
        ST_PROC: begin
          r_outVec[r_idx*BITWIDTH +: BITWIDTH] <= w_y;
          if (bus.dataReady) begin
            r_overrun <= 1'b1;
          end
          if (r_idx == LAST_IDX) begin
            r_state    <= ST_DONE;
            r_outValid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.dataReady) begin
            r_state <= ST_PROC;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.outputVector = r_outVec;
  assign bus.outValid     = r_outValid;
  assign bus.busy         = r_busy;
  assign bus.overrun      = r_overrun;

endmodule

// File: doc/gate_activation.md
# gate_activation

Per-gate activation stage placed directly downstream of the gate dot-product unit. It captures the NROW-element fixed-point vector on that unit's one-cycle `dataReady` pulse and optionally adds a per-row bias with saturation. It then applies a piecewise-linear sigmoid or tanh one element per cycle and presents the activated vector with a one-cycle `outValid` pulse to the LSTM cell-state logic.

## Interface
- `NROW`, 16, vector length (rows per gate)
- `QN`, 6, integer bits of signed Q format
- `QM`, 11, fractional bits; `BITWIDTH = QN+QM+1`
- `ACT_TYPE`, 0, activation: 0 = hard sigmoid, 1 = hard tanh
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `dataReady`  in  1  one-cycle pulse; `inputVector` valid this cycle
- `inputVector`  in  BITWIDTH*NROW  signed dot-product results, element i at `[i*BITWIDTH +: BITWIDTH]`
- `biasVector`  in  BITWIDTH*NROW  signed per-row bias, sampled with `dataReady`
- `outputVector`  out  BITWIDTH*NROW  activated results, same packing
- `outValid`  out  1  one-cycle pulse; `outputVector` complete
- `busy`  out  1  high in PROC and DONE
- `overrun`  out  1  sticky; `dataReady` arrived while in PROC

## Operation
- FSM states:
  - IDLE: `dataReady` captures inputs and clears idx -> PROC.
  - PROC: processes element idx each cycle. At idx == NROW-1 -> DONE.
  - DONE: `dataReady` re-captures -> PROC. Otherwise -> IDLE.
- `dataReady` in PROC is ignored and sets `overrun`. `overrun` clears only on reset.
- Per element:
  - s = x + b, computed at BITWIDTH+1 bits.
  - s is clamped to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
- Constants: ONE = 2^QM, HALF = 2^(QM-1).
- Hard sigmoid: y = clamp((s >>> 2) + HALF, 0, ONE), using an arithmetic shift.
- Hard tanh: y = clamp(s, -ONE, ONE).
- y is written to `outputVector` element idx. Other elements hold their values.
- `outputVector` is updated in place during the next PROC. Consumers sample it on `outValid`.
- Reset values: `outputVector`=0, `outValid`=0, `busy`=0, `overrun`=0, state IDLE, idx 0, capture registers 0.
- Reset asserted mid-PROC aborts the pass. No `outValid` is produced and all outputs return to reset values.

## Timing
- Edge E0 samples `dataReady`=1, giving state PROC and idx 0.
- Edges E1..E_NROW write elements 0..NROW-1.
- E_NROW sets state DONE and `outValid` to 1.
- E_{NROW+1} clears `outValid`.
- Latency: NROW edges from capture to `outValid` high.
- Throughput: one vector per NROW+1 cycles. Back-to-back is allowed via capture in DONE.
- `outValid` and `busy` are registered; no combinational input-to-output paths.

## Configuration
- Macro: `GATE_ACT_BIAS_EN`.
- Defined: bias capture registers exist, and the bias is added with saturation.
- Undefined: s = x, no bias registers, and `biasVector` stays a port but is ignored.
- Timing is identical in both builds.

## Structure
- Shared package holds:
  - the BITWIDTH derivation
  - state encodings (IDLE/PROC/DONE)
  - ACT_SIGMOID/ACT_TANH constants
  - ONE/HALF Q-format helpers, also reused by the cell-state stage
- One sub-module, `pwl_act`: combinational single-element bias-add, saturation and activation.
- The top level keeps the FSM, idx counter, capture registers and output vector.

## Test plan
- Sigmoid, all x=0, no bias -> every element 1024; `outValid` high exactly one cycle at E16; `busy` low after E17.
- Sigmoid, x = 4096 / -8192 / 8192 -> 2048 / 0 / 2048; x=-2048 -> 512.
- Tanh, x = -1000 / 5000 / -5000 -> -1000 / 2048 / -2048.
- Bias build: x=131071, b=10 (tanh) -> sum saturates to 131071 -> 2048. Non-bias build: x=0, b=2048 (sigmoid) -> 1024.
- `dataReady` at 5th PROC cycle -> ignored; `overrun`=1 and stays; output reflects the first vector. `dataReady` during DONE -> accepted, next `outValid` NROW edges later.
- `reset`=0 at 8th PROC cycle -> all outputs zero next edge, state IDLE, no `outValid`. Next `dataReady` after release processes normally.
